// File: rtl/dir_switch_ctrl_if.sv
// ---------------------------------------------------------------------------
// dir_switch_ctrl_if
// Bundles the pattern/direction signals of dir_switch_ctrl.
//   master : pattern sources and controls (cwsseg, ccwsseg, dir_req, tick, en)
//            plus the observed outputs
//   slave  : the controller; drives sseg, dir, switching
// Handshake: no valid/ready pair. tick is a one-cycle strobe, en is a level
// that freezes the controller when low; all signals are sampled on the
// rising edge of the controller clock.
// ---------------------------------------------------------------------------
interface dir_switch_ctrl_if #(
    parameter int W = 8
);
    logic [W-1:0] cwsseg;
    logic [W-1:0] ccwsseg;
    logic         dir_req;
    logic         tick;
    logic         en;
    logic [W-1:0] sseg;
    logic         dir;
    logic         switching;

    modport master (
        output cwsseg, ccwsseg, dir_req, tick, en,
        input  sseg, dir, switching
    );

    modport slave (
        input  cwsseg, ccwsseg, dir_req, tick, en,
        output sseg, dir, switching
    );
endinterface

// File: rtl/dir_switch_ctrl.sv
// ---------------------------------------------------------------------------
// dir_switch_ctrl
// Selects the clockwise or counter-clockwise segment pattern and inserts a
// blanking interval (all segments off, active-low) whenever the committed
// direction changes. Direction changes are rate-limited by a hold counter
// that counts rotation ticks.
// Ports:
//   clk      : clock, rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : dir_switch_ctrl_if.slave
//              in  cwsseg, ccwsseg, dir_req, tick, en
//              out sseg (registered), dir (committed), switching (=BLANK)
// The FSM state is visible on bus.switching, which is 1 exactly in BLANK.
// ---------------------------------------------------------------------------
module dir_switch_ctrl #(
    parameter int W          = 8,
    parameter int BLANK_CYC  = 4,
    parameter int HOLD_TICKS = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    dir_switch_ctrl_if.slave      bus
);

    localparam int HW = ($clog2(HOLD_TICKS + 1) > 1) ? $clog2(HOLD_TICKS + 1) : 1;
    localparam int BW = ($clog2(BLANK_CYC + 1) > 1) ? $clog2(BLANK_CYC + 1) : 1;

    localparam logic [HW-1:0] HOLD_LOAD  = HW'(HOLD_TICKS);
    // The blank counter counts down to 0 inclusive, so BLANK_CYC-1 gives
    // exactly BLANK_CYC cycles in BLANK.
    localparam logic [BW-1:0] BLANK_LOAD = (BLANK_CYC > 0) ? BW'(BLANK_CYC - 1) : '0;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_BLANK = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  sseg_q,  sseg_d;
    logic          dir_q,   dir_d;
    logic [HW-1:0] hcnt_q,  hcnt_d;
    logic [BW-1:0] bcnt_q,  bcnt_d;

    logic          commit;
    logic [W-1:0]  src_cur;
    logic [W-1:0]  src_req;

    assign src_cur = dir_q       ? bus.cwsseg : bus.ccwsseg;
    assign src_req = bus.dir_req ? bus.cwsseg : bus.ccwsseg;
    assign commit  = (state_q == ST_RUN) && bus.en && bus.tick &&
                     (bus.dir_req != dir_q) && (hcnt_q == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_RUN;
            sseg_q  <= '1;
            dir_q   <= 1'b1;
            hcnt_q  <= '0;
            bcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            sseg_q  <= sseg_d;
            dir_q   <= dir_d;
            hcnt_q  <= hcnt_d;
            bcnt_q  <= bcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sseg_d  = sseg_q;
        dir_d   = dir_q;
        hcnt_d  = hcnt_q;
        bcnt_d  = bcnt_q;

        // With en low every register holds, so tick and dir_req are ignored.
        if (bus.en) begin
            unique case (state_q)
                ST_RUN: begin
                    if (commit) begin
                        dir_d = bus.dir_req;
                        if (BLANK_CYC > 0) begin
                            state_d = ST_BLANK;
                            bcnt_d  = BLANK_LOAD;
                            sseg_d  = '1;
                        end else begin
                            sseg_d  = src_req;
                            hcnt_d  = HOLD_LOAD;
                        end
                    end else begin
                        sseg_d = src_cur;
                        // Saturating tick countdown; the commit branch above
                        // keeps a commit-cycle tick from consuming hold.
                        if (bus.tick && (hcnt_q != '0)) begin
                            hcnt_d = hcnt_q - 1'b1;
                        end
                    end
                end
                ST_BLANK: begin
                    if (bcnt_q == '0) begin
                        state_d = ST_RUN;
                        hcnt_d  = HOLD_LOAD;
                        sseg_d  = src_cur;
                    end else begin
                        bcnt_d  = bcnt_q - 1'b1;
                        sseg_d  = '1;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    assign bus.sseg      = sseg_q;
    assign bus.dir       = dir_q;
    assign bus.switching = (state_q == ST_BLANK);

endmodule
